pkt_rr_arbiter: RTL
===================

# pkt_rr_arbiter

Packet-aware round-robin arbiter that merges NUM_IN Avalon-ST packet streams, each sourced by a packet FIFO, onto one output stream. A grant is held from sop to eop, so packets never interleave. The merged beat passes through one registered output stage tagged with its source channel. The block sits between the per-port ingress FIFOs and the shared downstream parser.

## Interface
- NUM_IN, 4, number of input streams (2..16)
- DATA_WIDTH, 20, beat payload width
- CHAN_W, $clog2(NUM_IN), width of the channel tag

Ports:
- clk  in  1  single clock; all logic on its rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  NUM_IN  per-input beat valid
- in_ready  out  NUM_IN  per-input accept
- in_data  in  NUM_IN*DATA_WIDTH  payloads; input i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- in_sop  in  NUM_IN  per-input start of packet
- in_eop  in  NUM_IN  per-input end of packet
- out_valid  out  1  registered beat valid
- out_ready  in  1  downstream accept
- out_data  out  DATA_WIDTH  registered payload
- out_sop  out  1  registered sop
- out_eop  out  1  registered eop
- out_chan  out  CHAN_W  source input of the current beat
- err_orphan  out  1  one-cycle pulse when a non-sop head beat is dropped
- pkt_count  out  32  packets emitted (count of eop beats out); wraps

## Operation
- Definitions:
  - in_fire[i] = in_valid[i] && in_ready[i]
  - out_fire = out_valid && out_ready
  - load = !out_valid || out_ready (output register can take a beat this cycle)
- FSM states:
  - IDLE: no packet in flight.
  - LOCK: owner `gnt` is mid-packet.
- IDLE:
  - Requesters are inputs with in_valid && in_sop.
  - The round-robin picker searches from `ptr` upward with modulo wrap and selects the first requester as `sel`.
  - If a requester exists and load is true, in_ready[sel] = 1 and the beat is loaded.
  - If that beat has eop, the FSM stays in IDLE. Otherwise it goes to LOCK with gnt = sel.
  - Either way, ptr = (sel+1) mod NUM_IN.
- LOCK:
  - in_ready[gnt] = load. No other input is ready, except for orphan drops (below).
  - On in_fire[gnt] with eop, go to IDLE.
- Orphan drop:
  - Applies to any input i that is not the current owner (including all inputs in IDLE) and has in_valid && !in_sop.
  - in_ready[i] = 1, the beat is discarded, and err_orphan pulses.
  - Multiple simultaneous orphans produce a single pulse.
- Output register:
  - When a beat is loaded, out_data, out_sop, out_eop and out_chan are captured and out_valid is set.
  - When out_fire occurs and nothing is loaded, out_valid is cleared.
- pkt_count increments by 1 on out_fire && out_eop and wraps 2^32-1 -> 0.
- Reset values: state = IDLE, ptr = 0, gnt = 0, out_valid = 0, out_data = 0, out_sop = 0, out_eop = 0, out_chan = 0, err_orphan = 0, pkt_count = 0. in_ready is combinational; it is 0 during reset.

## Timing
- Latency: a beat accepted at edge N appears on the out_* ports after edge N and is valid in cycle N+1.
- Throughput is one beat per cycle while out_ready = 1.
- No bubble between packets: the eop of packet A and the sop of packet B (same or another input) are accepted on consecutive cycles, because IDLE arbitrates in the same cycle it is entered.
- in_ready depends combinationally on out_ready, in_valid and in_sop. No combinational path exists from in_data.
- Backpressure: with out_ready = 0 and out_valid = 1, every in_ready is 0 except orphan drops. The held beat is stable until out_fire.
- A single-beat packet (sop && eop) never enters LOCK.
- Owner starvation: if the owner deasserts in_valid mid-packet, the FSM stays in LOCK indefinitely. There is no timeout.
- Reset mid-packet:
  - Everything returns to reset values at once and the in-flight output beat is lost.
  - The remaining upstream beats of the interrupted packet are later dropped as orphans.

## Structure
- Package pkt_arb_pkg holds:
  - typedef enum logic {IDLE, LOCK} arb_state_t
  - localparam PKT_CNT_W = 32
- Sub-module rr_pick is combinational. It takes req[NUM_IN] and ptr[CHAN_W] and returns any and sel[CHAN_W]. It is implemented by a double-width rotate and priority encode.
- The top level holds the FSM, the ptr/gnt registers, the in_ready and orphan logic, the output register and the counter.

## Test plan
- Basic arbitration:
  - Stimulus: NUM_IN = 4; inputs 0 and 2 each present one 3-beat packet at the same cycle; out_ready = 1.
  - Response: output shows input 0's 3 beats (out_chan = 0), then input 2's 3 beats (out_chan = 2) with no gap; pkt_count = 2.
- Round-robin fairness:
  - Stimulus: all 4 inputs continuously offer 1-beat packets.
  - Response: out_chan sequence is 0,1,2,3,0,1,…; each input receives 25% of beats over 400 cycles.
- Backpressure and no interleave:
  - Stimulus: input 1 sends a 5-beat packet while out_ready toggles 1,0,0,1,…; input 3 raises sop at beat 2.
  - Response: input 1's beats are contiguous and unchanged during stalls; input 3's sop is accepted only after input 1's eop.
- Orphan drop:
  - Stimulus: in IDLE, input 2 presents a valid beat with sop = 0, data 0xABCDE.
  - Response: in_ready[2] = 1, err_orphan pulses for 1 cycle, no out_valid, pkt_count unchanged.
- Reset mid-packet:
  - Stimulus: assert rst_n = 0 at beat 2 of a 4-beat packet from input 0; release; input 0 sends beats 3 and 4 without sop.
  - Response: out_valid = 0 and ptr = 0 after reset; beats 3 and 4 are dropped, each with an err_orphan pulse.
- Counter wrap:
  - Stimulus: force pkt_count to 32'hFFFF_FFFF; send one packet.
  - Response: pkt_count = 0 after its eop leaves the output.

Source files
------------

// File: rtl/pkt_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pkt_arb_pkg                                                     |
// | Purpose  : Shared types and constants for the packet round-robin arbiter.  |
// |            arb_state_t : arbiter FSM state (IDLE / LOCK)                   |
// |            PKT_CNT_W   : width of the emitted-packet counter               |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package pkt_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,  // no packet in flight, arbitrate among sop requesters
    LOCK = 1'b1   // grant held by the owner until its eop is accepted
  } arb_state_t;

  localparam int PKT_CNT_W = 32;

endpackage : pkt_arb_pkg
`default_nettype wire

// File: rtl/pkt_rr_arbiter_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rr_pick                                                         |
// | Purpose  : Combinational round-robin picker. Starting at ptr and wrapping  |
// |            modulo NUM_IN, returns the first asserted request.              |
// | Ports    : req [NUM_IN] in  - request vector                               |
// |            ptr [CHAN_W] in  - highest-priority index (must be < NUM_IN)    |
// |            any          out - at least one request is asserted             |
// |            sel [CHAN_W] out - index of the winning request                 |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module rr_pick #(
  parameter int NUM_IN = 4,
  parameter int CHAN_W = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [CHAN_W-1:0] ptr,
  output logic              any,
  output logic [CHAN_W-1:0] sel
);

  localparam logic [CHAN_W:0] c_num_in = (CHAN_W+1)'(NUM_IN);

  logic [2*NUM_IN-1:0] w_dbl;
  logic [NUM_IN-1:0]   w_rot;
  logic [CHAN_W-1:0]   w_off;
  logic                w_found;
  logic [CHAN_W:0]     w_sum;

  // Duplicating the vector turns the modulo rotate into a plain window select:
  // bit k of the window is request (ptr + k) mod NUM_IN.
  assign w_dbl = {req, req};

  always_comb begin
    w_rot = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      w_rot[k] = w_dbl[int'(ptr) + k];
    end
  end

  // Lowest set bit of the rotated window is the distance from ptr to the winner.
  always_comb begin
    w_off   = '0;
    w_found = 1'b0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (!w_found && w_rot[k]) begin
        w_off   = CHAN_W'(k);
        w_found = 1'b1;
      end
    end
  end

  // Map the offset back to an absolute index; one conditional subtract suffices
  // because ptr and offset are both below NUM_IN.
  always_comb begin
    w_sum = {1'b0, ptr} + {1'b0, w_off};
    if (w_sum >= c_num_in) begin
      w_sum = w_sum - c_num_in;
    end
  end

  assign any = |req;
  assign sel = w_sum[CHAN_W-1:0];

endmodule : rr_pick
`default_nettype wire

// File: rtl/pkt_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pkt_rr_arbiter                                                  |
// | Purpose  : Packet-aware round-robin merge of NUM_IN Avalon-ST streams onto |
// |            one registered output. A grant is held sop..eop so packets      |
// |            never interleave; non-sop beats from non-owners are dropped.    |
// | Ports    : clk, rst_n         - clock, async active-low reset              |
// |            in_valid/in_ready  - per-input handshake                        |
// |            in_data/sop/eop    - per-input beat (input i at i*DATA_WIDTH)   |
// |            out_valid/out_ready- output handshake (registered valid)        |
// |            out_data/sop/eop   - registered beat                            |
// |            out_chan           - source input of the current output beat    |
// |            err_orphan         - one-cycle pulse per cycle with a drop      |
// |            pkt_count          - wrapping count of eop beats emitted        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module pkt_rr_arbiter
  import pkt_arb_pkg::*;
#(
  parameter int NUM_IN     = 4,
  parameter int DATA_WIDTH = 20,
  parameter int CHAN_W     = $clog2(NUM_IN)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_IN-1:0]            in_valid,
  output logic [NUM_IN-1:0]            in_ready,
  input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]            in_sop,
  input  logic [NUM_IN-1:0]            in_eop,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         out_sop,
  output logic                         out_eop,
  output logic [CHAN_W-1:0]            out_chan,
  output logic                         err_orphan,
  output logic [PKT_CNT_W-1:0]         pkt_count
);

  localparam logic [CHAN_W-1:0] c_last_idx = CHAN_W'(NUM_IN - 1);

  arb_state_t           r_state;
  logic [CHAN_W-1:0]    r_ptr;
  logic [CHAN_W-1:0]    r_gnt;
  logic                 r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                 r_out_sop;
  logic                 r_out_eop;
  logic [CHAN_W-1:0]    r_out_chan;
  logic                 r_err_orphan;
  logic [PKT_CNT_W-1:0] r_pkt_count;

  logic                  w_load;
  logic [NUM_IN-1:0]     w_req;
  logic                  w_any;
  logic [CHAN_W-1:0]     w_sel;
  logic [CHAN_W-1:0]     w_ptr_next;
  logic [NUM_IN-1:0]     w_orphan;
  logic [NUM_IN-1:0]     w_ready;
  logic                  w_take;
  logic [CHAN_W-1:0]     w_idx;
  logic [DATA_WIDTH-1:0] w_beat_data [NUM_IN];
  logic                  w_out_fire;

  // Output register can accept a new beat when empty or draining this cycle.
  assign w_load     = !r_out_valid || out_ready;
  assign w_out_fire = r_out_valid && out_ready;
  assign w_req      = in_valid & in_sop;

  rr_pick #(
    .NUM_IN (NUM_IN),
    .CHAN_W (CHAN_W)
  ) u_rr_pick (
    .req (w_req),
    .ptr (r_ptr),
    .any (w_any),
    .sel (w_sel)
  );

  assign w_ptr_next = (w_sel == c_last_idx) ? '0 : w_sel + CHAN_W'(1);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IN; gi++) begin : g_lane
      assign w_beat_data[gi] = in_data[gi*DATA_WIDTH +: DATA_WIDTH];
      // Any non-sop beat not belonging to the current owner has no packet to
      // join; it is always accepted and thrown away so the FIFO can resync.
      assign w_orphan[gi] = in_valid[gi] && !in_sop[gi] &&
                            !((r_state == LOCK) && (r_gnt == CHAN_W'(gi)));
    end
  endgenerate

  always_comb begin
    w_ready = w_orphan;
    w_take  = 1'b0;
    if (r_state == IDLE) begin
      if (w_any && w_load) begin
        w_ready[w_sel] = 1'b1;
        w_take         = 1'b1;
      end
    end else begin
      if (w_load) begin
        w_ready[r_gnt] = 1'b1;
      end
      w_take = w_load && in_valid[r_gnt];
    end
  end

  // No handshake may complete while reset is asserted.
  assign in_ready = rst_n ? w_ready : '0;

  // Mux select depends only on state and sop/valid, never on data.
  assign w_idx = (r_state == LOCK) ? r_gnt : w_sel;

  // Arbitration FSM with round-robin pointer and owner register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_gnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any && w_load) begin
            r_ptr <= w_ptr_next;
            if (!in_eop[w_sel]) begin
              r_state <= LOCK;
              r_gnt   <= w_sel;
            end
          end
        end
        LOCK: begin
          if (w_take && in_eop[r_gnt]) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sop   <= 1'b0;
      r_out_eop   <= 1'b0;
      r_out_chan  <= '0;
    end else if (w_take) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_beat_data[w_idx];
      r_out_sop   <= in_sop[w_idx];
      r_out_eop   <= in_eop[w_idx];
      r_out_chan  <= w_idx;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Orphans are always ready, so a pending orphan is also a dropped one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_orphan <= 1'b0;
      r_pkt_count  <= '0;
    end else begin
      r_err_orphan <= |w_orphan;
      if (w_out_fire && r_out_eop) begin
        r_pkt_count <= r_pkt_count + PKT_CNT_W'(1);
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_sop    = r_out_sop;
  assign out_eop    = r_out_eop;
  assign out_chan   = r_out_chan;
  assign err_orphan = r_err_orphan;
  assign pkt_count  = r_pkt_count;

endmodule : pkt_rr_arbiter
`default_nettype wire
